// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing generator: 640x480@60 defaults,
// frame-total derivation and coordinate width.
package vga_timing_pkg;

  localparam int unsigned CoordW   = 10;
  localparam int unsigned MaxTotal = 1 << CoordW;

  localparam int unsigned DefHVisible = 640;
  localparam int unsigned DefHFront   = 16;
  localparam int unsigned DefHSync    = 96;
  localparam int unsigned DefHBack    = 48;
  localparam int unsigned DefVVisible = 480;
  localparam int unsigned DefVFront   = 10;
  localparam int unsigned DefVSync    = 2;
  localparam int unsigned DefVBack    = 33;
  localparam bit          DefSyncPol  = 1'b0;

  function automatic int unsigned axis_total(input int unsigned visible,
                                             input int unsigned front,
                                             input int unsigned sync,
                                             input int unsigned back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: enabled position counter that wraps at TOTAL-1, plus the
// visible-region and sync-window decodes for that axis.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned VISIBLE  = DefHVisible,
  parameter int unsigned FRONT    = DefHFront,
  parameter int unsigned SYNC     = DefHSync,
  parameter int unsigned BACK     = DefHBack,
  parameter bit          SYNC_POL = DefSyncPol
) (
  input  logic              clk,
  input  logic              restart_n,
  input  logic              en,
  output logic [CoordW-1:0] count,
  output logic              wrap,
  output logic              sync,
  output logic              visible
);

  localparam int unsigned Total     = axis_total(VISIBLE, FRONT, SYNC, BACK);
  localparam int unsigned SyncStart = VISIBLE + FRONT;
  localparam int unsigned SyncEnd   = SyncStart + SYNC;
  localparam logic [CoordW-1:0] Last = CoordW'(Total - 1);

  logic [CoordW-1:0] count_d, count_q;
  logic [31:0]       count_ext;
  logic              at_last;
  logic              in_sync;

  assign at_last = (count_q == Last);

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = at_last ? '0 : count_q + CoordW'(1);
    end
  end

  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Widen before comparing so window bounds up to MaxTotal never truncate.
  assign count_ext = 32'(count_q);
  assign in_sync   = (count_ext >= SyncStart) && (count_ext < SyncEnd);

  assign count   = count_q;
  assign wrap    = en & at_last;
  assign visible = (count_ext < VISIBLE);
  assign sync    = in_sync ? SYNC_POL : ~SYNC_POL;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel coordinates, syncs, active video and line/frame ticks.
// Define VGA_TIMING_OUTREG_EN to register every output (one clk of latency, all aligned).
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = DefHVisible,
  parameter int unsigned H_FRONT    = DefHFront,
  parameter int unsigned H_SYNC     = DefHSync,
  parameter int unsigned H_BACK     = DefHBack,
  parameter int unsigned V_VISIBLE  = DefVVisible,
  parameter int unsigned V_FRONT    = DefVFront,
  parameter int unsigned V_SYNC     = DefVSync,
  parameter int unsigned V_BACK     = DefVBack,
  parameter bit          H_SYNC_POL = DefSyncPol,
  parameter bit          V_SYNC_POL = DefSyncPol
) (
  input  logic              clk,
  input  logic              restart_n,
  input  logic              pixel_en,
  output logic [CoordW-1:0] x,
  output logic [CoordW-1:0] y,
  output logic              video_on,
  output logic              hsync,
  output logic              vsync,
  output logic              line_tick,
  output logic              frame_tick
);

  localparam int unsigned HTotal = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned VTotal = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  if (HTotal > MaxTotal) begin : g_h_total_check
    $error("vga_timing: horizontal total exceeds coordinate range");
  end
  if (VTotal > MaxTotal) begin : g_v_total_check
    $error("vga_timing: vertical total exceeds coordinate range");
  end

  logic [CoordW-1:0] h_count, v_count;
  logic              h_wrap, v_wrap;
  logic              h_sync_c, v_sync_c;
  logic              h_vis, v_vis;
  logic              v_en;

  // The vertical axis only steps on the enabled cycle that ends a line.
  assign v_en = h_wrap;

  vga_axis_counter #(
    .VISIBLE  (H_VISIBLE),
    .FRONT    (H_FRONT),
    .SYNC     (H_SYNC),
    .BACK     (H_BACK),
    .SYNC_POL (H_SYNC_POL)
  ) u_h_axis (
    .clk       (clk),
    .restart_n (restart_n),
    .en        (pixel_en),
    .count     (h_count),
    .wrap      (h_wrap),
    .sync      (h_sync_c),
    .visible   (h_vis)
  );

  vga_axis_counter #(
    .VISIBLE  (V_VISIBLE),
    .FRONT    (V_FRONT),
    .SYNC     (V_SYNC),
    .BACK     (V_BACK),
    .SYNC_POL (V_SYNC_POL)
  ) u_v_axis (
    .clk       (clk),
    .restart_n (restart_n),
    .en        (v_en),
    .count     (v_count),
    .wrap      (v_wrap),
    .sync      (v_sync_c),
    .visible   (v_vis)
  );

`ifdef VGA_TIMING_OUTREG_EN
  logic [CoordW-1:0] x_q, y_q;
  logic              video_on_q, hsync_q, vsync_q, line_tick_q, frame_tick_q;

  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      x_q          <= '0;
      y_q          <= '0;
      video_on_q   <= 1'b0;
      hsync_q      <= ~H_SYNC_POL;
      vsync_q      <= ~V_SYNC_POL;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      x_q          <= h_count;
      y_q          <= v_count;
      video_on_q   <= h_vis & v_vis;
      hsync_q      <= h_sync_c;
      vsync_q      <= v_sync_c;
      line_tick_q  <= h_wrap;
      frame_tick_q <= v_wrap;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign video_on   = video_on_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign line_tick  = line_tick_q;
  assign frame_tick = frame_tick_q;
`else
  assign x          = h_count;
  assign y          = v_count;
  assign video_on   = h_vis & v_vis;
  assign hsync      = h_sync_c;
  assign vsync      = v_sync_c;
  assign line_tick  = h_wrap;
  assign frame_tick = v_wrap;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: a reduced 32x20 raster (hsync active-high) and a default
// 800x525 raster driven from the same clock, reset and pixel enable.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic restart_n = 1'b0;
  logic pixel_en  = 1'b0;

  logic [9:0] s_x, s_y, d_x, d_y;
  logic s_video_on, s_hsync, s_vsync, s_line_tick, s_frame_tick;
  logic d_video_on, d_hsync, d_vsync, d_line_tick, d_frame_tick;

  vga_timing #(
    .H_VISIBLE  (16),
    .H_FRONT    (4),
    .H_SYNC     (8),
    .H_BACK     (4),
    .V_VISIBLE  (12),
    .V_FRONT    (2),
    .V_SYNC     (2),
    .V_BACK     (4),
    .H_SYNC_POL (1'b1),
    .V_SYNC_POL (1'b0)
  ) u_small (
    .clk        (clk),
    .restart_n  (restart_n),
    .pixel_en   (pixel_en),
    .x          (s_x),
    .y          (s_y),
    .video_on   (s_video_on),
    .hsync      (s_hsync),
    .vsync      (s_vsync),
    .line_tick  (s_line_tick),
    .frame_tick (s_frame_tick)
  );

  vga_timing u_dflt (
    .clk        (clk),
    .restart_n  (restart_n),
    .pixel_en   (pixel_en),
    .x          (d_x),
    .y          (d_y),
    .video_on   (d_video_on),
    .hsync      (d_hsync),
    .vsync      (d_vsync),
    .line_tick  (d_line_tick),
    .frame_tick (d_frame_tick)
  );

  int checks = 0;
  int fails  = 0;

  // Enabled-cycle counts since reset release: before and after the latest clock edge.
  int n_prev = -1;
  int n_cur  = 0;
  bit in_reset = 1'b1;

  logic [24:0] s_obs, s_exp, d_obs, d_exp;
  assign s_obs = {s_x, s_y, s_video_on, s_hsync, s_vsync, s_line_tick, s_frame_tick};
  assign d_obs = {d_x, d_y, d_video_on, d_hsync, d_vsync, d_line_tick, d_frame_tick};

  // Expected outputs for a raster that has seen n enabled cycles; n < 0 means the
  // registered build still shows its reset values.
  function automatic logic [24:0] expv(input int n, input logic pe,
                                       input int hv, input int hf, input int hs, input int hb,
                                       input int vv, input int vf, input int vs, input int vb,
                                       input logic hp, input logic vp);
    int ht, vt, h, v;
    logic vid, hsy, vsy, lt, ft;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    if (n < 0) return {20'd0, 1'b0, ~hp, ~vp, 2'b00};
    h   = n % ht;
    v   = (n / ht) % vt;
    vid = (h < hv) && (v < vv);
    hsy = ((h >= hv + hf) && (h < hv + hf + hs)) ? hp : ~hp;
    vsy = ((v >= vv + vf) && (v < vv + vf + vs)) ? vp : ~vp;
    lt  = pe && (h == ht - 1);
    ft  = lt && (v == vt - 1);
    return {10'(h), 10'(v), vid, hsy, vsy, lt, ft};
  endfunction

  function automatic int sel_n();
`ifdef VGA_TIMING_OUTREG_EN
    return n_prev;
`else
    return n_cur;
`endif
  endfunction

  function automatic logic [24:0] small_exp();
    return expv(sel_n(), pixel_en, 16, 4, 8, 4, 12, 2, 2, 4, 1'b1, 1'b0);
  endfunction

  function automatic logic [24:0] dflt_exp();
    return expv(sel_n(), pixel_en, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
  endfunction

  // One clock: apply pe, take the edge, advance the model, stop on the falling edge.
  task automatic cycle(input logic pe);
    pixel_en = pe;
    @(posedge clk);
    if (!in_reset) begin
      n_prev = n_cur;
      n_cur  = n_cur + int'(pe);
    end
    @(negedge clk);
  endtask

  task automatic assert_reset();
    restart_n = 1'b0;
    in_reset  = 1'b1;
    n_prev    = -1;
    n_cur     = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    restart_n = 1'b1;
    in_reset  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    pixel_en = 1'b1;
    #2;
    assert_reset();
    #1;
    s_exp = small_exp();
    d_exp = dflt_exp();
    checks++;
    if (s_obs !== s_exp)
      $display("FAIL reset_small: got x=%0d y=%0d flags=%b, expected x=%0d y=%0d flags=%b",
               s_obs[24:15], s_obs[14:5], s_obs[4:0], s_exp[24:15], s_exp[14:5], s_exp[4:0]);
    if (s_obs !== s_exp) fails++;
    checks++;
    if (d_obs !== d_exp) begin
      fails++;
      $display("FAIL reset_dflt: got x=%0d y=%0d flags=%b, expected x=%0d y=%0d flags=%b",
               d_obs[24:15], d_obs[14:5], d_obs[4:0], d_exp[24:15], d_exp[14:5], d_exp[4:0]);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1);
      s_exp = small_exp();
      checks++;
      if (s_obs !== s_exp) begin
        fails++;
        $display("FAIL reset_hold: got x=%0d y=%0d flags=%b, expected x=%0d y=%0d flags=%b",
                 s_obs[24:15], s_obs[14:5], s_obs[4:0], s_exp[24:15], s_exp[14:5], s_exp[4:0]);
      end
    end
  endtask

  task automatic test_full_rate();
    int frames = 0;
    release_reset();
    for (int i = 0; i < 1300; i++) begin
      cycle(1'b1);
      s_exp = small_exp();
      d_exp = dflt_exp();
      checks++;
      if (s_obs !== s_exp) begin
        fails++;
        $display("FAIL run_small cyc %0d: got x=%0d y=%0d flags=%b, expected x=%0d y=%0d flags=%b",
                 i, s_obs[24:15], s_obs[14:5], s_obs[4:0], s_exp[24:15], s_exp[14:5],
                 s_exp[4:0]);
      end
      checks++;
      if (d_obs !== d_exp) begin
        fails++;
        $display("FAIL run_dflt cyc %0d: got x=%0d y=%0d flags=%b, expected x=%0d y=%0d flags=%b",
                 i, d_obs[24:15], d_obs[14:5], d_obs[4:0], d_exp[24:15], d_exp[14:5],
                 d_exp[4:0]);
      end
      if (s_frame_tick === 1'b1) frames++;
    end
    checks++;
    if (frames !== 2) begin
      fails++;
      $display("FAIL run_frame_count: got %0d, expected 2", frames);
    end
  endtask

  task automatic test_half_rate();
    int ticks = 0;
    int first = -1;
    int second = -1;
    assert_reset();
    cycle(1'b0);
    release_reset();
    for (int i = 0; i < 2700; i++) begin
      cycle((i % 2) == 0);
      s_exp = small_exp();
      d_exp = dflt_exp();
      checks++;
      if (s_obs !== s_exp) begin
        fails++;
        $display("FAIL half_small cyc %0d: got x=%0d y=%0d flags=%b, expected x=%0d y=%0d flags=%b",
                 i, s_obs[24:15], s_obs[14:5], s_obs[4:0], s_exp[24:15], s_exp[14:5],
                 s_exp[4:0]);
      end
      checks++;
      if (d_obs !== d_exp) begin
        fails++;
        $display("FAIL half_dflt cyc %0d: got x=%0d y=%0d flags=%b, expected x=%0d y=%0d flags=%b",
                 i, d_obs[24:15], d_obs[14:5], d_obs[4:0], d_exp[24:15], d_exp[14:5],
                 d_exp[4:0]);
      end
      if (s_frame_tick === 1'b1) begin
        ticks++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    checks++;
    if (ticks !== 2) begin
      fails++;
      $display("FAIL half_frame_count: got %0d, expected 2", ticks);
    end
    checks++;
    if (second - first !== 1280) begin
      fails++;
      $display("FAIL half_frame_period: got %0d clk, expected 1280", second - first);
    end
  endtask

  task automatic test_midframe_reset();
    assert_reset();
    cycle(1'b1);
    release_reset();
    // Run to (10,6) on the small raster: 6*32 + 10 enabled cycles.
    for (int i = 0; i < 202; i++) cycle(1'b1);
    checks++;
    if (n_cur != 202 || {s_x, s_y} !== {10'd10, 10'd6}) begin
      fails++;
      $display("FAIL mid_position: got x=%0d y=%0d, expected x=10 y=6", s_x, s_y);
    end
    #2;
    assert_reset();
    #1;
    s_exp = small_exp();
    d_exp = dflt_exp();
    checks++;
    if (s_obs !== s_exp) begin
      fails++;
      $display("FAIL mid_async_small: got x=%0d y=%0d flags=%b, expected x=%0d y=%0d flags=%b",
               s_obs[24:15], s_obs[14:5], s_obs[4:0], s_exp[24:15], s_exp[14:5], s_exp[4:0]);
    end
    checks++;
    if (d_obs !== d_exp) begin
      fails++;
      $display("FAIL mid_async_dflt: got x=%0d y=%0d flags=%b, expected x=%0d y=%0d flags=%b",
               d_obs[24:15], d_obs[14:5], d_obs[4:0], d_exp[24:15], d_exp[14:5], d_exp[4:0]);
    end
    @(negedge clk);
    cycle(1'b1);
    release_reset();
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1);
      s_exp = small_exp();
      checks++;
      if (s_obs !== s_exp) begin
        fails++;
        $display("FAIL mid_resume cyc %0d: got x=%0d y=%0d flags=%b, expected x=%0d y=%0d flags=%b",
                 i, s_obs[24:15], s_obs[14:5], s_obs[4:0], s_exp[24:15], s_exp[14:5],
                 s_exp[4:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_half_rate();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator for the VGA display path. It counts pixel positions across a configurable horizontal/vertical frame and produces sync pulses, the active-video flag and pixel coordinates. It also emits one-cycle line and frame pulses. The pixel generator consumes the coordinates, and the animation counters downstream use `frame_tick` as their increment source.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `H_SYNC_POL`, 0, hsync active level (0 = active-low)
- `V_SYNC_POL`, 0, vsync active level (0 = active-low)

Ports:
- `clk`  in  1  system clock
- `restart_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `pixel_en`  in  1  pixel-rate enable; counters advance only on cycles where it is high
- `x`  out  10  horizontal position, 0..H_TOTAL-1
- `y`  out  10  vertical position, 0..V_TOTAL-1
- `video_on`  out  1  high when x < H_VISIBLE and y < V_VISIBLE
- `hsync`  out  1  horizontal sync at H_SYNC_POL level during the sync interval
- `vsync`  out  1  vertical sync at V_SYNC_POL level during the sync interval
- `line_tick`  out  1  one-clk pulse when the horizontal counter wraps
- `frame_tick`  out  1  one-clk pulse when both counters wrap

## Operation
- H_TOTAL = sum of the H_* parameters (default 800); V_TOTAL = sum of the V_* parameters (default 525). Both must be ≤ 1024; elaboration error otherwise.
- Horizontal counter `h`:
  - On `pixel_en` high, increments.
  - At H_TOTAL-1 it wraps to 0.
- Vertical counter `v`:
  - Increments only on `pixel_en` high while `h` = H_TOTAL-1.
  - At V_TOTAL-1 (with `h` wrap) it wraps to 0.
- `pixel_en` low: counters hold and all decodes hold. `line_tick` and `frame_tick` are 0.
- `x` = `h`, `y` = `v`.
- hsync is active for `h` in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC). Default: 656..751.
- vsync is active for `v` in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC). Default: 490..491.
- `line_tick` = `pixel_en` & (`h` == H_TOTAL-1).
- `frame_tick` = `line_tick` & (`v` == V_TOTAL-1).
- Reset (restart_n low, any time including mid-frame):
  - Counters clear to 0 immediately.
  - On the first `pixel_en` after release, the counters go to (1,0).

## Timing
- Base build: outputs decode combinationally from the counter registers, so there is zero latency from counter state.
  - During reset: x=0, y=0, video_on=1, hsync=!H_SYNC_POL, vsync=!V_SYNC_POL.
  - Ticks follow `pixel_en` combinationally and are 0 with default totals.
- Frame period: H_TOTAL·V_TOTAL `pixel_en` cycles (420000 for defaults).
- With `pixel_en` tied high, the period is exactly 420000 clk. With `pixel_en` at 1/2 rate, it is 840000 clk.
- Ticks never last more than one clk, regardless of `pixel_en` duty.

## Configuration
- Macro `VGA_TIMING_OUTREG_EN`.
- Defined: every output passes through one register stage clocked every clk.
  - All outputs are delayed exactly 1 clk and stay mutually aligned.
  - Reset values: x=0, y=0, video_on=0, syncs inactive, ticks 0.
- Undefined: combinational outputs as above.

## Structure
- Package `vga_timing_pkg` holds:
  - the default 640x480@60 constants;
  - the H_TOTAL/V_TOTAL derivation;
  - the coordinate width constant (10).
- Sub-module `vga_axis_counter` is instantiated twice (horizontal, vertical). It holds:
  - a count with clock enable;
  - wrap at TOTAL-1 with a wrap output;
  - sync-window and visible decode with polarity parameter.

## Test plan
- Reset release, `pixel_en`=1: x runs 0..799, `line_tick` at x=799, y steps 0→1 on the next clk, and the pattern repeats.
- Sync windows: hsync low exactly for x 656..751 (96 clk). vsync low exactly for y 490..491 (1600 clk). video_on low for x ≥ 640 or y ≥ 480.
- `pixel_en` alternating 1/0: counters advance every other clk, no tick occurs on disabled cycles, and the frame period is 840000 clk.
- `frame_tick`: exactly one pulse per 420000 enabled cycles, coincident with (799,524), then (0,0) follows.
- Reset asserted mid-frame at (300,200): outputs go to reset values with no clock edge, and counting resumes from (0,0) after release.
- `VGA_TIMING_OUTREG_EN` defined: repeat the first two scenarios. Every output trails the base build by exactly 1 clk, and x/y/syncs/ticks remain aligned.
